sp_ram_arb: RTL and testbench

Two-requester arbiter and sequencer for the single-port RAM (`sp_ram`: `data[7:0]`, `addr[5:0]`, `we`, `clk`, `Q[7:0]`). It sits between two client blocks (A and B) and the one RAM instance. It serialises their read and write transactions over a 3-cycle req/ack handshake and returns read data to the client that issued the read. All RAM-side outputs are registered.

---
 rtl/sp_ram_arb.sv | 112 +++++++++++
 tb/tb_sp_ram_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arb.sv
`default_nettype none
// sp_ram_arb: arbitrates two clients onto one single-port RAM with a 3-cycle req/ack sequence.
// Optional round-robin tie-break enabled by defining SP_RAM_ARB_RR_EN. Rev 1.0
module sp_ram_arb #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic          owner;      // 0 = A, 1 = B
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;
  logic          grant_b;

`ifdef SP_RAM_ARB_RR_EN
  logic last_b;

  // Tie goes to whoever was not granted last; reset value lets A win first.
  assign grant_b = b_req & (~a_req | ~last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (state == IDLE && (a_req | b_req)) begin
      last_b <= grant_b;
    end
  end
`else
  assign grant_b = b_req & ~a_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (a_req | b_req) begin
            state    <= ISSUE;
            owner    <= grant_b;
            ram_addr <= grant_b ? b_addr  : a_addr;
            ram_data <= grant_b ? b_wdata : a_wdata;
            ram_we   <= grant_b ? b_we    : a_we;
          end
        end
        ISSUE: begin
          state  <= DONE;
          ram_we <= 1'b0;
          a_ack  <= ~owner;
          b_ack  <= owner;
        end
        DONE: begin
          state <= IDLE;
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (a_ack) a_rdata_q <= ram_q;
          if (b_ack) b_rdata_q <= ram_q;
        end
        default: begin
          state  <= IDLE;
          a_ack  <= 1'b0;
          b_ack  <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

  // Q only settles at the edge ending ISSUE, so the ack cycle forwards it live
  // and the holding register keeps it from then on.
  assign a_rdata = a_ack ? ram_q : a_rdata_q;
  assign b_rdata = b_ack ? ram_q : b_rdata_q;
  assign busy    = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arb.sv
`default_nettype none
// tb_sp_ram_arb: directed vector table, corner sequences and randomized traffic for sp_ram_arb.
module tb_sp_ram_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [5:0] a_addr, b_addr, ram_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_data;
  logic       a_ack, b_ack, ram_we, busy;
  logic [7:0] ram_q = 8'h00;

  int checks = 0;
  int failures = 0;

  sp_ram_arb #(.DW(8), .AW(6)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Behavioural single-port RAM: Q registered, write-through on writes.
  logic [7:0] mem [64];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= ram_we ? ram_data : mem[ram_addr];
    end
  end

  // Reference contents, updated at transaction level.
  logic [7:0] ref_mem [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_ack"}, a_ack, 0);
    chk({tag, "_b_ack"}, b_ack, 0);
    chk({tag, "_a_rdata"}, a_rdata, 0);
    chk({tag, "_b_rdata"}, b_rdata, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_data"}, ram_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    bit         cl;      // 0 = A, 1 = B
    bit         we;
    logic [5:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
  } vec_t;

  // Single isolated transaction, entered at the start of an IDLE cycle.
  task automatic run_txn(input vec_t v);
    if (!v.cl) begin a_req = 1; a_we = v.we; a_addr = v.addr; a_wdata = v.wd; end
    else       begin b_req = 1; b_we = v.we; b_addr = v.addr; b_wdata = v.wd; end
    @(negedge clk);
    chk("c0_busy", busy, 0);
    chk("c0_ram_we", ram_we, 0);
    next_cycle();
    @(negedge clk);
    chk("c1_busy", busy, 1);
    chk("c1_ram_we", ram_we, v.we);
    chk("c1_ram_addr", ram_addr, v.addr);
    if (v.we) chk("c1_ram_data", ram_data, v.wd);
    chk("c1_no_ack", a_ack | b_ack, 0);
    next_cycle();
    @(negedge clk);
    chk("c2_busy", busy, 1);
    chk("c2_ram_we", ram_we, 0);
    chk("c2_a_ack", a_ack, !v.cl);
    chk("c2_b_ack", b_ack, v.cl);
    chk("c2_rdata", v.cl ? b_rdata : a_rdata, v.exp_rd);
    next_cycle();
    a_req = 0; b_req = 0;
    @(negedge clk);
    chk("c3_busy", busy, 0);
    chk("c3_no_ack", a_ack | b_ack, 0);
    chk("c3_rdata_hold", v.cl ? b_rdata : a_rdata, v.exp_rd);
    next_cycle();
    if (v.we) ref_mem[v.addr] = v.wd;
  endtask

  task automatic do_reset();
    rst = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_reset_vals("rst");
    next_cycle();
    rst = 0;
  endtask

  vec_t vecs [7];

  initial begin
    int gc;
    bit ow, last_b, sa, sb, win, exp_a, exp_b;
    logic [7:0] erd;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;

    vecs[0] = '{cl: 0, we: 1, addr: 6'd0,  wd: 8'hAA, exp_rd: 8'hAA};
    vecs[1] = '{cl: 0, we: 1, addr: 6'd1,  wd: 8'hBB, exp_rd: 8'hBB};
    vecs[2] = '{cl: 0, we: 0, addr: 6'd1,  wd: 8'h00, exp_rd: 8'hBB};
    vecs[3] = '{cl: 0, we: 0, addr: 6'd3,  wd: 8'h00, exp_rd: init_val(3)};
    vecs[4] = '{cl: 0, we: 1, addr: 6'd63, wd: 8'h3C, exp_rd: 8'h3C};
    vecs[5] = '{cl: 1, we: 0, addr: 6'd0,  wd: 8'h00, exp_rd: 8'hAA};
    vecs[6] = '{cl: 1, we: 0, addr: 6'd63, wd: 8'h00, exp_rd: 8'h3C};

    do_reset();
    for (int k = 0; k < 7; k++) run_txn(vecs[k]);

    // Tie: A write 0xCC @2 wins, B read @2 follows and sees 0xCC.
    a_req = 1; a_we = 1; a_addr = 6'd2; a_wdata = 8'hCC;
    b_req = 1; b_we = 0; b_addr = 6'd2; b_wdata = 8'h00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("tie_a_ack", a_ack, c == 2);
      chk("tie_b_ack", b_ack, c == 5);
      if (c == 2) chk("tie_a_rdata", a_rdata, 8'hCC);
      if (c == 5) chk("tie_b_rdata", b_rdata, 8'hCC);
      next_cycle();
      if (c == 2) a_req = 0;
      if (c == 5) b_req = 0;
    end
    ref_mem[2] = 8'hCC;

    // Continuous dual reads: A @0, B @1; last grant was B.
    a_req = 1; a_we = 0; a_addr = 6'd0;
    b_req = 1; b_we = 0; b_addr = 6'd1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
`ifdef SP_RAM_ARB_RR_EN
      exp_a = (c == 2) || (c == 8);
      exp_b = (c == 5) || (c == 11);
`else
      exp_a = (c % 3) == 2;
      exp_b = 0;
`endif
      chk("cont_a_ack", a_ack, exp_a);
      chk("cont_b_ack", b_ack, exp_b);
      if (exp_a) chk("cont_a_rdata", a_rdata, 8'hAA);
      if (exp_b) chk("cont_b_rdata", b_rdata, 8'hBB);
      next_cycle();
    end
    a_req = 0; b_req = 0;

    // Reset during ISSUE of a B write 0xDD @1: write lands, no ack.
    b_req = 1; b_we = 1; b_addr = 6'd1; b_wdata = 8'hDD;
    @(negedge clk);
    chk("rsti_c0_busy", busy, 0);
    next_cycle();
    rst = 1; b_req = 0;
    @(negedge clk);
    chk("rsti_c1_ram_we", ram_we, 1);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk_reset_vals("rsti_post");
    next_cycle();
    ref_mem[1] = 8'hDD;
    run_txn('{cl: 0, we: 0, addr: 6'd1, wd: 8'h00, exp_rd: 8'hDD});

    // Randomized traffic against a transaction-level timing model.
    do_reset();
    gc = -10; ow = 0; erd = 0; last_b = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_a = (c == gc + 2) && !ow;
      exp_b = (c == gc + 2) && ow;
      chk("rnd_a_ack", a_ack, exp_a);
      chk("rnd_b_ack", b_ack, exp_b);
      chk("rnd_busy", busy, (c == gc + 1) || (c == gc + 2));
      if (exp_a) chk("rnd_a_rdata", a_rdata, erd);
      if (exp_b) chk("rnd_b_rdata", b_rdata, erd);
      if (c >= gc + 3 && (a_req || b_req)) begin
`ifdef SP_RAM_ARB_RR_EN
        win = (a_req && b_req) ? !last_b : b_req;
`else
        win = !a_req;
`endif
        last_b = win;
        ow = win;
        gc = c;
        if (win ? b_we : a_we) begin
          erd = win ? b_wdata : a_wdata;
          ref_mem[win ? b_addr : a_addr] = erd;
        end else begin
          erd = ref_mem[win ? b_addr : a_addr];
        end
      end
      sa = a_ack; sb = b_ack;
      next_cycle();
      if (sa) a_req = 0;
      else if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1; a_we = 1'($urandom_range(0, 1));
        a_addr = 6'($urandom_range(0, 7)); a_wdata = 8'($urandom);
      end
      if (sb) b_req = 0;
      else if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1; b_we = 1'($urandom_range(0, 1));
        b_addr = 6'($urandom_range(0, 7)); b_wdata = 8'($urandom);
      end
    end
    a_req = 0; b_req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
